m_keypad_scan: RTL and testbench

- Scanner and encoder for the calculator's 4x4 matrix keypad.
- Drives keypad rows, samples columns, debounces, and emits one 4-bit key code per press.
- The code set matches the calculator's 7-segment display code: 0-9 digits, a=+, b=-, c=*, d=/, e==, f=clear/blank.
- Sits between the keypad pins and the calculator control FSM; its codes feed the display path unchanged.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/m_key_sync.sv | 26 ++
 rtl/m_keypad_scan.sv | 142 ++++++++++++++
 tb/tb_m_keypad_scan.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-code table for the calculator keypad scanner.
// Codes match the 7-segment display code set so they pass straight through.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_ADD = 4'ha;
  localparam logic [3:0] KEY_SUB = 4'hb;
  localparam logic [3:0] KEY_MUL = 4'hc;
  localparam logic [3:0] KEY_DIV = 4'hd;
  localparam logic [3:0] KEY_EQ  = 4'he;
  localparam logic [3:0] KEY_CLR = 4'hf;

  // Index = row*4 + col; entry 0 is the rightmost element.
  localparam logic [15:0][3:0] KEY_MAP = {
    KEY_DIV, KEY_EQ, 4'h0, KEY_CLR,   // row3
    KEY_MUL, 4'h9,   4'h8, 4'h7,      // row2
    KEY_SUB, 4'h6,   4'h5, 4'h4,      // row1
    KEY_ADD, 4'h3,   4'h2, 4'h1       // row0
  };

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEY_MAP[idx];
  endfunction

endpackage

// File: rtl/m_key_sync.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
module m_key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/m_keypad_scan.sv
// 4x4 keypad scanner: rotates row drive, collects one full scan of columns,
// debounces over whole scans and emits one code per accepted press.
module m_keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]    w_col_sync;
  logic [3:0]    w_hit;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [11:0]   r_scan;
  logic [15:0]   w_full;
  logic [4:0]    w_nbits;
  logic [3:0]    w_idx;
  logic          w_sample;
  logic          w_eval;
  logic          w_none;
  logic          w_single;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rcnt;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_rcnt_inc;
  logic          w_accept;
  logic [3:0]    r_code;
  logic          r_valid;

  m_key_sync #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (col_i),
    .o_q   (w_col_sync)
  );

  assign w_hit    = ~w_col_sync;
  assign w_sample = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_eval   = w_sample && (r_row == 2'd3);

  // Scan never stalls: dwell counter and row rotation run in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_row   <= 2'd0;
      r_scan  <= '0;
    end else if (w_sample) begin
      r_dwell <= '0;
      r_row   <= r_row + 2'd1;
      case (r_row)
        2'd0:    r_scan[3:0]  <= w_hit;
        2'd1:    r_scan[7:4]  <= w_hit;
        2'd2:    r_scan[11:8] <= w_hit;
        default: ;
      endcase
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Row 3 is folded in combinationally on the evaluation cycle.
  assign w_full = {w_hit, r_scan};

  always_comb begin
    w_nbits = '0;
    w_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_full[i]) begin
        w_nbits = w_nbits + 5'd1;
        w_idx   = 4'(i);
      end
    end
  end

  assign w_none     = (w_nbits == 5'd0);
  assign w_single   = (w_nbits == 5'd1);
  assign w_cnt_inc  = (r_state == DEBOUNCE && w_idx == r_cand) ? r_cnt + CW'(1) : CW'(1);
  assign w_rcnt_inc = r_rcnt + CW'(1);
  assign w_accept   = w_eval && w_single && (r_state != HELD) &&
                      (w_cnt_inc == CW'(DEBOUNCE_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_eval) begin
      case (r_state)
        IDLE:     if (w_single) w_state_nxt = w_accept ? HELD : DEBOUNCE;
        DEBOUNCE: w_state_nxt = w_single ? (w_accept ? HELD : DEBOUNCE) : IDLE;
        HELD:     if (w_none && w_rcnt_inc == CW'(DEBOUNCE_CNT)) w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand  <= '0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
      r_code  <= KEY_CLR;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) r_code <= key_lookup(w_idx);
      if (w_eval) begin
        if (w_single && r_state != HELD) begin
          r_cand <= w_idx;
          r_cnt  <= w_cnt_inc;
        end
        if (r_state == HELD) r_rcnt <= w_none ? w_rcnt_inc : '0;
        else                 r_rcnt <= '0;
      end
    end
  end

  always_comb begin
    row_o     = ~(4'b0001 << r_row);
    key_code  = r_code;
    key_valid = r_valid;
    key_held  = (r_state == HELD);
  end

endmodule

// File: tb/tb_m_keypad_scan.sv
// Keypad scanner bench: a simulated key matrix plus a per-scan reference model.
module tb_m_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int M_IDLE = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_fail = 0;

  int         m_st, m_cand, m_cnt, m_rcnt;
  logic [3:0] m_code;
  logic       m_held, m_pulse;

  always #5 clk = ~clk;

  m_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_i     (col_i),
    .row_o     (row_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Pressed switch shorts its row to its column; columns are pulled up.
  always_comb begin
    col_i = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_o[r] && keys[r*4+c]) col_i[c] = 1'b0;
  end

  function automatic logic [3:0] map_code(input int idx);
    case (idx)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'ha;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hb;
      8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hc;
      12: return 4'hf; 13: return 4'h0; 14: return 4'he; default: return 4'hd;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cand = 0; m_cnt = 0; m_rcnt = 0;
    m_code = 4'hf; m_held = 1'b0; m_pulse = 1'b0;
  endtask

  // Apply the debounce rules to one complete scan of a constant key set.
  task automatic model_scan(input logic [15:0] k);
    int   n, idx;
    logic acc;
    n = $countones(k); idx = 0; acc = 1'b0; m_pulse = 1'b0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    if (m_st == M_IDLE) begin
      if (n == 1) begin
        m_cand = idx; m_cnt = 1; m_st = M_DEB; acc = (m_cnt >= DB);
      end
    end else if (m_st == M_DEB) begin
      if (n == 1) begin
        if (idx == m_cand) m_cnt++;
        else begin m_cand = idx; m_cnt = 1; end
        acc = (m_cnt >= DB);
      end else m_st = M_IDLE;
    end else begin
      if (n == 0) m_rcnt++; else m_rcnt = 0;
      if (m_rcnt >= DB) begin m_st = M_IDLE; m_held = 1'b0; end
    end
    if (acc) begin
      m_st = M_HELD; m_rcnt = 0; m_pulse = 1'b1; m_held = 1'b1;
      m_code = map_code(m_cand);
    end
  endtask

  // Runs ncyc cycles of one scan (16 = complete), checking every cycle.
  task automatic do_scan(input logic [15:0] k, input int ncyc);
    logic [3:0] exp_row;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << (c / SD));
      chk("row_o", row_o, exp_row);
      chk("key_valid", key_valid, (c == 0) ? m_pulse : 1'b0);
      chk("key_held", key_held, m_held);
      chk("key_code", key_code, m_code);
      if (c == 0) keys = k;
    end
    if (ncyc == 16) model_scan(k);
  endtask

  task automatic do_reset(input logic [15:0] k);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_row_o", row_o, 4'he);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    chk("rst_code", key_code, 4'hf);
    keys = k;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic scans(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) do_scan(k, 16);
  endtask

  logic [15:0] cur;
  int          r;

  initial begin
    model_reset();
    do_reset('0);
    scans('0, 2);

    // steady '5', then release
    scans(16'h0020, 5);
    scans('0, 4);

    // bounce, then stable '5'
    scans(16'h0020, 2); scans('0, 1); scans(16'h0020, 2); scans('0, 2);
    scans(16'h0020, 4); scans('0, 4);

    // MULTI blocks acceptance; reduce to single 'f'
    scans(16'h1008, 3); scans(16'h1000, 4); scans('0, 4);

    // long '=' hold, then '/'
    scans(16'h4000, 20); scans('0, 4);
    scans(16'h8000, 4); scans('0, 4);

    // reset during debounce of '7' with key still held
    scans(16'h0100, 2);
    do_scan(16'h0100, 6);
    do_reset(16'h0100);
    scans(16'h0100, 4); scans('0, 4);

    // randomized key activity with occasional mid-scan resets
    cur = '0;
    for (int s = 0; s < 80; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       cur = '0;
      else if (r < 16) cur = 16'h0001 << $urandom_range(0, 15);
      else if (r < 19) cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        do_scan(cur, int'($urandom_range(1, 15)));
        do_reset(cur);
      end else begin
        do_scan(cur, 16);
      end
    end
    scans('0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
